// File: rtl/lif_neuron_core_n.sv
// lif_neuron_core_n: multi-channel leaky integrate-and-fire neuron core.
// Weights, leak, threshold and refractory length are loaded over the
// two-wire serial port (load_mode / serial_data), MSB first:
//   W[0] .. W[NUM_CH-1] (8 b each), leak (8 b), threshold (VM_W b), refrac (4 b).
// A frame is committed on the falling edge of load_mode only if exactly
// FRAME bits were taken.
// Optional feature macro: LIF_ADAPTIVE_THRESHOLD_EN (adaptive threshold offset).
module lif_neuron_core_n #(
   parameter int NUM_CH = 2,
   parameter int IN_W   = 3,
   parameter int VM_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   input  logic [NUM_CH*IN_W-1:0] ch_in,
   input  logic                   load_mode,
   input  logic                   serial_data,
   output logic                   params_ready,
   output logic [VM_W-1:0]        v_mem,
   output logic                   spike,
   output logic                   refractory_active
);

   localparam int FRAME = 8*NUM_CH + 8 + VM_W + 4;
   localparam int CW    = $clog2(FRAME + 2);
   localparam int SW    = VM_W + IN_W + 8 + 4;

   logic [FRAME-1:0]    stage_r;
   logic [CW-1:0]       bit_cnt_r;
   logic                load_q_r;
   logic [NUM_CH*8-1:0] w_r;
   logic [7:0]          leak_r;
   logic [VM_W-1:0]     th_r;
   logic [3:0]          refrac_r;
   logic [3:0]          rcnt_r;

   logic                commit_s;
   logic                run_s;
   logic                fire_s;
   logic [SW-1:0]       sum_s;
   logic [SW:0]         up_s;
   logic [SW:0]         diff_s;
   logic [VM_W-1:0]     v_next_s;
   logic [VM_W:0]       th_eff_s;

   // A valid commit is a falling load_mode edge after exactly FRAME taken bits.
   assign commit_s = ena & ~load_mode & load_q_r & (bit_cnt_r == CW'(FRAME));
   assign run_s    = ena & ~load_mode & params_ready;

   // Weighted input sum over all channels, wide enough to never overflow.
   always_comb begin
      sum_s = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         sum_s = sum_s + SW'(ch_in[k*IN_W +: IN_W]) * SW'(w_r[k*8 +: 8]);
      end
   end

   // Membrane update candidate: v + sum - leak, clamped to the VM_W range.
   always_comb begin
      up_s   = (SW+1)'(v_mem) + (SW+1)'(sum_s);
      diff_s = up_s - (SW+1)'(leak_r);
      if (up_s < (SW+1)'(leak_r)) begin
         v_next_s = '0;
      end else if (diff_s > (SW+1)'({VM_W{1'b1}})) begin
         v_next_s = {VM_W{1'b1}};
      end else begin
         v_next_s = diff_s[VM_W-1:0];
      end
   end

`ifdef LIF_ADAPTIVE_THRESHOLD_EN
   logic [3:0] adapt_r;
   logic [3:0] decay_r;

   assign th_eff_s = {1'b0, th_r} + (VM_W+1)'(adapt_r);

   // Adaptive offset: bump on each spike, bleed one step per decay-timer wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adapt_r <= 4'd0;
         decay_r <= 4'd0;
      end else if (ena) begin
         decay_r <= decay_r + 4'd1;
         if (commit_s) begin
            adapt_r <= 4'd0;
         end else if (fire_s) begin
            if (adapt_r != 4'd15) begin
               adapt_r <= adapt_r + 4'd1;
            end else begin
               adapt_r <= adapt_r;
            end
         end else if ((decay_r == 4'd15) && (adapt_r != 4'd0)) begin
            adapt_r <= adapt_r - 4'd1;
         end else begin
            adapt_r <= adapt_r;
         end
      end else begin
         adapt_r <= adapt_r;
         decay_r <= decay_r;
      end
   end
`else
   assign th_eff_s = {1'b0, th_r};
`endif

   assign fire_s = run_s & (rcnt_r == 4'd0) & ({1'b0, v_next_s} >= th_eff_s);

   // Serial loader: shift bits in while loading, commit staging on valid exit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_r      <= '0;
         bit_cnt_r    <= '0;
         load_q_r     <= 1'b0;
         params_ready <= 1'b0;
         w_r          <= '0;
         leak_r       <= 8'd0;
         th_r         <= '0;
         refrac_r     <= 4'd0;
      end else if (ena) begin
         load_q_r <= load_mode;
         if (load_mode) begin
            stage_r <= {stage_r[FRAME-2:0], serial_data};
            if (!load_q_r) begin
               bit_cnt_r    <= CW'(1);
               params_ready <= 1'b0;
            end else if (bit_cnt_r != CW'(FRAME + 1)) begin
               bit_cnt_r <= bit_cnt_r + CW'(1);
            end else begin
               bit_cnt_r <= bit_cnt_r;
            end
         end else if (commit_s) begin
            for (int k = 0; k < NUM_CH; k++) begin
               w_r[k*8 +: 8] <= stage_r[FRAME-1-8*k -: 8];
            end
            leak_r       <= stage_r[VM_W+11:VM_W+4];
            th_r         <= stage_r[VM_W+3:4];
            refrac_r     <= stage_r[3:0];
            params_ready <= 1'b1;
         end else begin
            params_ready <= params_ready;
         end
      end else begin
         load_q_r <= load_q_r;
      end
   end

   // Neuron datapath: integrate, fire, and count down the refractory period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_mem             <= '0;
         spike             <= 1'b0;
         rcnt_r            <= 4'd0;
         refractory_active <= 1'b0;
      end else begin
         spike <= 1'b0;
         if (commit_s) begin
            v_mem             <= '0;
            rcnt_r            <= 4'd0;
            refractory_active <= 1'b0;
         end else if (run_s) begin
            if (rcnt_r != 4'd0) begin
               v_mem             <= '0;
               rcnt_r            <= rcnt_r - 4'd1;
               refractory_active <= (rcnt_r != 4'd1);
            end else if (fire_s) begin
               spike             <= 1'b1;
               v_mem             <= '0;
               rcnt_r            <= refrac_r;
               refractory_active <= (refrac_r != 4'd0);
            end else begin
               v_mem <= v_next_s;
            end
         end else begin
            v_mem <= v_mem;
         end
      end
   end

endmodule

// File: tb/tb_lif_neuron_core_n.sv
// Scoreboard bench for lif_neuron_core_n (default build).
module tb_lif_neuron_core_n;
   localparam int NUM_CH = 2;
   localparam int IN_W   = 3;
   localparam int VM_W   = 8;
   localparam int FRAME  = 8*NUM_CH + 8 + VM_W + 4;
   localparam int CHW    = NUM_CH*IN_W;
   localparam int VMAX   = (1 << VM_W) - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            ena = 1'b0;
   logic [CHW-1:0]  ch_in = '0;
   logic            load_mode = 1'b0;
   logic            serial_data = 1'b0;
   logic            params_ready;
   logic [VM_W-1:0] v_mem;
   logic            spike;
   logic            refractory_active;

   lif_neuron_core_n #(.NUM_CH(NUM_CH), .IN_W(IN_W), .VM_W(VM_W)) dut (
      .clk(clk), .rst(rst), .ena(ena), .ch_in(ch_in), .load_mode(load_mode),
      .serial_data(serial_data), .params_ready(params_ready), .v_mem(v_mem),
      .spike(spike), .refractory_active(refractory_active));

   always #5 clk = ~clk;

   typedef struct { int v; bit sp; bit ra; bit pr; } exp_t;
   exp_t exp_q[$];
   int checks = 0;
   int passes = 0;

   // reference model state
   int m_w[NUM_CH];
   int m_leak, m_th, m_ref, m_v, m_rc;
   bit m_pr, m_lp, m_spike;
   bit bits[$];

   function automatic int field(input int s, input int l);
      int r = 0;
      for (int i = 0; i < l; i++) r = r*2 + int'(bits[s+i]);
      return r;
   endfunction

   task automatic model_reset();
      foreach (m_w[k]) m_w[k] = 0;
      m_leak = 0; m_th = 0; m_ref = 0; m_v = 0; m_rc = 0;
      m_pr = 0; m_lp = 0; m_spike = 0;
      bits.delete();
   endtask

   task automatic model_step();
      int sum, vn;
      m_spike = 0;
      if (!ena) return;
      if (load_mode) begin
         if (!m_lp) begin bits.delete(); m_pr = 0; end
         bits.push_back(serial_data);
         m_lp = 1;
      end else begin
         if (m_lp && bits.size() == FRAME) begin
            for (int k = 0; k < NUM_CH; k++) m_w[k] = field(8*k, 8);
            m_leak = field(8*NUM_CH, 8);
            m_th   = field(8*NUM_CH + 8, VM_W);
            m_ref  = field(8*NUM_CH + 8 + VM_W, 4);
            m_v = 0; m_rc = 0; m_pr = 1;
         end else if (m_pr) begin
            if (m_rc > 0) begin
               m_v = 0; m_rc--;
            end else begin
               sum = 0;
               for (int k = 0; k < NUM_CH; k++) sum += int'(ch_in[k*IN_W +: IN_W]) * m_w[k];
               vn = m_v + sum - m_leak;
               if (vn < 0) vn = 0;
               if (vn > VMAX) vn = VMAX;
               if (vn >= m_th) begin m_spike = 1; m_v = 0; m_rc = m_ref; end
               else m_v = vn;
            end
         end
         m_lp = 0;
      end
   endtask

   task automatic drive(input bit e, input bit lm, input bit sd, input logic [CHW-1:0] c);
      @(negedge clk);
      ena = e; load_mode = lm; serial_data = sd; ch_in = c;
      model_step();
      exp_q.push_back('{m_v, m_spike, (m_rc != 0), m_pr});
   endtask

   function automatic logic [FRAME-1:0] mkf(input int w0, input int w1, input int lk,
                                             input int th, input int rf);
      return {8'(w0), 8'(w1), 8'(lk), VM_W'(th), 4'(rf)};
   endfunction

   task automatic load(input logic [FRAME-1:0] f, input int n, input bit gaps);
      int i = 0;
      while (i < n) begin
         if (gaps && ($urandom % 4 == 0)) begin
            drive(1'b0, 1'b1, 1'($urandom % 2), CHW'($urandom));
         end else begin
            drive(1'b1, 1'b1, (i < FRAME) ? f[FRAME-1-i] : 1'($urandom % 2), CHW'($urandom));
            i++;
         end
      end
      drive(1'b1, 1'b0, 1'b0, ch_in);
   endtask

   task automatic run(input int n, input logic [CHW-1:0] c, input bit rnd);
      for (int i = 0; i < n; i++) begin
         if (rnd) drive(($urandom % 8) != 0, 1'b0, 1'b0, CHW'($urandom));
         else     drive(1'b1, 1'b0, 1'b0, c);
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (v_mem !== '0 || spike !== 1'b0 || params_ready !== 1'b0 || refractory_active !== 1'b0)
         $display("FAIL %s: v_mem=%0d spike=%0b pr=%0b ra=%0b, required all 0",
                  name, v_mem, spike, params_ready, refractory_active);
      else passes++;
   endtask

   // Monitor: compare DUT outputs against the queued expectation after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (v_mem !== VM_W'(e.v) || spike !== e.sp || refractory_active !== e.ra ||
                params_ready !== e.pr)
               $display("FAIL cycle t=%0t: v_mem=%0d spike=%0b ra=%0b pr=%0b, required v_mem=%0d spike=%0b ra=%0b pr=%0b",
                        $time, v_mem, spike, refractory_active, params_ready, e.v, e.sp, e.ra, e.pr);
            else passes++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      #1 check_zero("reset_initial");
      @(negedge clk); rst = 1'b0;

      // basic integrate / fire / refractory
      load(mkf(10, 0, 2, 50, 3), FRAME, 1'b0);
      run(14, CHW'(1), 1'b0);
      // leak floor
      load(mkf(0, 0, 5, 50, 1), FRAME, 1'b1);
      run(8, '0, 1'b1);
      // saturation at the top of the membrane range
      load(mkf(200, 0, 0, 255, 2), FRAME, 1'b0);
      run(8, CHW'(1), 1'b0);
      // bad frames: short and long, parameters must freeze
      load(mkf(1, 1, 0, 3, 1), FRAME-1, 1'b0);
      run(6, CHW'(9), 1'b0);
      load(mkf(1, 1, 0, 3, 1), FRAME+1, 1'b1);
      run(6, CHW'(9), 1'b0);
      // threshold zero fires on every non-refractory cycle
      load(mkf(3, 4, 1, 0, 0), FRAME, 1'b0);
      run(6, CHW'(5), 1'b1);
      // randomized parameter sets
      for (int t = 0; t < 12; t++) begin
         load(mkf($urandom % 256, $urandom % 256, $urandom % 64, $urandom % 256, $urandom % 16),
              ($urandom % 6 == 0) ? FRAME + 1 - 2*($urandom % 2) : FRAME, 1'b1);
         run(20, '0, 1'b1);
      end

      // asynchronous reset in the middle of a refractory period
      load(mkf(10, 0, 2, 50, 5), FRAME, 1'b0);
      run(9, CHW'(1), 1'b0);
      @(posedge clk); #3;
      rst = 1'b1;
      #1 check_zero("reset_async_refractory");
      model_reset();
      @(negedge clk); rst = 1'b0;
      run(3, CHW'(1), 1'b0);
      @(posedge clk); #3;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/lif_neuron_core_n.md
# lif_neuron_core_n

Parametrised leaky integrate-and-fire neuron core: the multi-channel successor to the two-channel 3-bit LIF tile. It takes NUM_CH weighted input channels and integrates them into a VM_W-bit membrane with linear leak. On threshold crossing it emits a one-cycle spike and enters a programmable refractory period. All weights, leak, threshold and refractory length arrive over the same two-wire serial load port (load_mode / serial_data) the tile pins expose, so the core drops in behind the top-level pin wrapper.

## Interface
- NUM_CH, 2: number of input channels (1..8)
- IN_W, 3: width of each unsigned channel input
- VM_W, 8: membrane/threshold width (8..16)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ena  in  1  global enable; 0 freezes all state including loading
- ch_in  in  NUM_CH*IN_W  channel inputs, ch k at [k*IN_W +: IN_W], unsigned
- load_mode  in  1  1 = serial load active, integration halted
- serial_data  in  1  load bit, sampled each ena cycle while load_mode=1
- params_ready  out  1  valid parameter set committed
- v_mem  out  VM_W  membrane potential (registered)
- spike  out  1  one-cycle spike pulse (registered)
- refractory_active  out  1  refractory counter nonzero

## Operation
- Frame, MSB first, FRAME = 8*NUM_CH + 8 + VM_W + 4 bits: W[0], W[1], … W[NUM_CH-1] (8 b unsigned each), leak (8 b), threshold (VM_W b), refrac (4 b). Default FRAME = 36.
- Loading: while load_mode=1, shift serial_data into a staging register and increment bit_cnt, which saturates at FRAME+1.
- Entering load_mode (0→1): bit_cnt cleared, params_ready cleared.
- Commit on load_mode 1→0:
  - bit_cnt==FRAME: staging copied to active params, v_mem=0, refractory counter=0, params_ready=1.
  - Otherwise: active params unchanged, params_ready stays 0.
- Integration runs only when ena=1, load_mode=0 and params_ready=1; otherwise v_mem holds.
- Integration step with refractory count 0:
  - sum = Σ ch_in[k]*W[k], computed in VM_W+IN_W+8+4 bits.
  - v_next = v_mem + sum − leak, clamped to [0, 2^VM_W−1].
  - If v_next ≥ th_eff: spike=1, v_mem=0, rcnt=refrac.
  - Else: v_mem=v_next.
- Refractory (rcnt>0): no integration, v_mem=0, rcnt decrements by 1 each enabled cycle, spike=0.
- refractory_active = (rcnt != 0).
- th_eff = threshold when the macro is absent. threshold=0 gives a spike on every non-refractory integration cycle.

## Timing
- Reset: v_mem=0, spike=0, params_ready=0, refractory_active=0, all params=0, bit_cnt=0, adapt=0.
- All outputs registered; 1-cycle latency from ch_in sample to v_mem/spike.
- spike is high for exactly one cycle per crossing.
- refrac=R gives R cycles with v_mem=0, then integration resumes.
- params_ready rises on the cycle after the falling load_mode edge of a valid frame.
- rst mid-load discards the frame. rst mid-refractory clears rcnt.
- ena=0 during a load pauses shifting; the bit is not taken.

## Configuration
- LIF_ADAPTIVE_THRESHOLD_EN defined:
  - 4-bit adapt register; th_eff = threshold + adapt, compared in VM_W+1 bits.
  - Each spike increments adapt, saturating at 15.
  - A free-running 4-bit decay timer (advances when ena=1) decrements adapt by 1 on wrap if adapt>0.
  - Spike and wrap in the same cycle: increment only.
  - adapt cleared on commit and on reset.
- Undefined: no adapt logic, th_eff = threshold.

## Test plan
- Reset: rst=1 mid-activity → all outputs 0 in the same cycle (asynchronous).
- Load W0=10, W1=0, leak=2, th=50, refrac=3; hold ch0=1, ch1=0.
  - Required: params_ready=1, then v_mem 8,16,24,32,40,48.
  - Next cycle: spike=1 with v_mem=0.
  - Then 3 cycles with refractory_active=1 and v_mem=0, then v_mem=8.
- Leak floor: W=0, leak=5 → v_mem stays 0, no spike.
- Saturation: VM_W=8, th=255, sum−leak=200/cycle → v_mem 200, then spike (255≥255).
- Bad frame: 35 bits then load_mode 0 → params_ready=0, v_mem frozen, old params retained. 37 bits → same result.
- With LIF_ADAPTIVE_THRESHOLD_EN, first scenario: the second spike needs v_next ≥ 51. Check the adapt value after 16 idle cycles.
